// File: rtl/alu_result_sel_pkg.sv
// Purpose: shared types and operation-channel codes for the ALU result selector.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: selector FSM state enum, op-code channel numbers, and a range-check helper.
package alu_sel_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    // Channel numbers of the operation units feeding the selector.
    localparam int OP_ADD    = 0;
    localparam int OP_SUB    = 1;
    localparam int OP_X2     = 2;
    localparam int OP_D2     = 3;
    localparam int OP_AND    = 4;
    localparam int OP_OR     = 5;
    localparam int OP_XOR    = 6;
    localparam int OP_NOT    = 7;
    localparam int OP_EQ     = 8;
    localparam int OP_GT     = 9;
    localparam int OP_LT     = 10;
    localparam int OP_MAX    = 11;
    localparam int OP_KNIGHT = 12;
    localparam int OP_SADD   = 13;
    localparam int OP_SSUB   = 14;
    localparam int OP_NONE   = 15;

    // True when a channel number addresses a real operation unit.
    function automatic logic chan_valid(input int chan, input int num_ops);
        return (chan >= 0) && (chan < num_ops);
    endfunction

endpackage

// File: rtl/alu_result_sel_if.sv
// Purpose: bundles the operation-result bus and the display/LED outputs of the selector.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are plain levels or single-cycle strobes.
//
// Signals: op_data/op_flag/op_dp_mask/led_pattern/sel/sel_load/scan_en (to selector),
//          result/led/dp_n/cur_sel/sel_changed (from selector), freeze when ALU_SEL_FREEZE_EN.
// master = operation units + controls side, slave = the selector itself.
interface alu_result_sel_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_OPS = 16,
    parameter int SEL_W   = 4
);
    logic [NUM_OPS*WIDTH-1:0] op_data;
    logic [NUM_OPS-1:0]       op_flag;
    logic [NUM_OPS-1:0]       op_dp_mask;
    logic [WIDTH+1:0]         led_pattern;
    logic [SEL_W-1:0]         sel;
    logic                     sel_load;
    logic                     scan_en;
`ifdef ALU_SEL_FREEZE_EN
    logic                     freeze;
`endif
    logic [WIDTH-1:0]         result;
    logic [WIDTH+1:0]         led;
    logic                     dp_n;
    logic [SEL_W-1:0]         cur_sel;
    logic                     sel_changed;

    modport master (
        output op_data, op_flag, op_dp_mask, led_pattern, sel, sel_load, scan_en,
`ifdef ALU_SEL_FREEZE_EN
        output freeze,
`endif
        input  result, led, dp_n, cur_sel, sel_changed
    );

    modport slave (
        input  op_data, op_flag, op_dp_mask, led_pattern, sel, sel_load, scan_en,
`ifdef ALU_SEL_FREEZE_EN
        input  freeze,
`endif
        output result, led, dp_n, cur_sel, sel_changed
    );

endinterface

// File: rtl/alu_result_sel_scan_tick_gen.sv
// Purpose: scan-step timer; counts 0..SCAN_TICKS-1 while enabled, pulses tick at terminal count.
// Latency: tick is combinational from the counter; counter wraps on the edge after tick.
// Backpressure: none; clr (or rst) forces the count to 0 and overrides en.
//
// Ports: clk, rst (sync, active-high), en (count), clr (sync clear), tick (terminal-count pulse).
module scan_tick_gen #(
    parameter int SCAN_TICKS = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = (SCAN_TICKS > 2) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_TICKS - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_result_sel.sv
// Purpose: registered selector of one operation result for the 7-segment display and LED bank.
// Latency: one edge; outputs follow the next value of cur_sel, so they move with cur_sel.
// Backpressure: none; optional freeze (ALU_SEL_FREEZE_EN) holds the display outputs only.
//
// Ports: clk, rst (sync, active-high), bus (alu_result_sel_if.slave).
// Modes: MANUAL latches sel on sel_load; SCAN steps cur_sel every SCAN_TICKS clocks.
// Build option: define ALU_SEL_FREEZE_EN to add the freeze input on the interface.
module alu_result_sel
    import alu_sel_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int NUM_OPS     = 16,
    parameter int SEL_W       = 4,
    parameter int SCAN_TICKS  = 50_000_000,
    parameter int LED_PASS_OP = OP_KNIGHT
) (
    input  logic              clk,
    input  logic              rst,
    alu_result_sel_if.slave   bus
);

    state_t           state;
    logic [SEL_W-1:0] cur_sel_q;
    logic [SEL_W-1:0] cur_sel_nxt;
    logic             cnt_en;
    logic             step;
    logic             out_upd;

    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH+1:0] led_nxt;
    logic             dp_n_nxt;

    // Counter only runs while we are, and will stay, in SCAN; dropping scan_en on
    // the terminal-count cycle therefore clears it instead of producing a step.
    assign cnt_en = (state == SCAN) && bus.scan_en;

    scan_tick_gen #(
        .SCAN_TICKS (SCAN_TICKS)
    ) u_scan_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .clr  (!cnt_en),
        .tick (step)
    );

`ifdef ALU_SEL_FREEZE_EN
    assign out_upd = !bus.freeze;
`else
    assign out_upd = 1'b1;
`endif

    // Next selection. In MANUAL a load wins even when scan_en is also high; the
    // FSM enters SCAN on the same edge.
    always_comb begin
        cur_sel_nxt = cur_sel_q;
        case (state)
            MANUAL: begin
                if (bus.sel_load) begin
                    cur_sel_nxt = bus.sel;
                end
            end
            SCAN: begin
                if (step) begin
                    // >= also pulls an out-of-range manual value back into the loop.
                    if (32'(cur_sel_q) >= NUM_OPS - 1) begin
                        cur_sel_nxt = '0;
                    end else begin
                        cur_sel_nxt = cur_sel_q + SEL_W'(1);
                    end
                end
            end
            default: cur_sel_nxt = cur_sel_q;
        endcase
    end

    // Output mapping for the upcoming selection. Constant-index loop keeps the
    // mux free of variable part-selects.
    always_comb begin
        res_nxt  = '0;
        led_nxt  = '0;
        dp_n_nxt = 1'b1;
        if (chan_valid(32'(cur_sel_nxt), NUM_OPS)) begin
            if (32'(cur_sel_nxt) == LED_PASS_OP) begin
                led_nxt = bus.led_pattern;
            end else begin
                for (int k = 0; k < NUM_OPS; k++) begin
                    if (32'(cur_sel_nxt) == k) begin
                        res_nxt  = bus.op_data[k*WIDTH +: WIDTH];
                        led_nxt  = {bus.op_flag[k], 1'b0, bus.op_data[k*WIDTH +: WIDTH]};
                        dp_n_nxt = !(bus.op_flag[k] && bus.op_dp_mask[k]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= MANUAL;
            cur_sel_q       <= '0;
            bus.sel_changed <= 1'b0;
            bus.result      <= '0;
            bus.led         <= '0;
            bus.dp_n        <= 1'b1;
        end else begin
            case (state)
                MANUAL:  state <= bus.scan_en ? SCAN : MANUAL;
                SCAN:    state <= bus.scan_en ? SCAN : MANUAL;
                default: state <= MANUAL;
            endcase
            cur_sel_q       <= cur_sel_nxt;
            bus.sel_changed <= (cur_sel_nxt != cur_sel_q);
            if (out_upd) begin
                bus.result <= res_nxt;
                bus.led    <= led_nxt;
                bus.dp_n   <= dp_n_nxt;
            end
        end
    end

    assign bus.cur_sel = cur_sel_q;

endmodule
